// File: rtl/sm83_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sm83_decode_unit
//  Purpose  : Three-stage SM83 opcode decoder. Raw field/opcode terms (d),
//             instruction classes (w) and datapath strobes (x), registered
//             together so every output snapshot is self-consistent.
//  Revision : 1.0  initial release
// ============================================================================
module sm83_decode_unit (
  input  logic         CLK,
  input  logic         nRESET,
  input  logic [7:0]   IR,
  input  logic         CB,
  input  logic [2:0]   MCYC,
  output logic [106:0] d,
  output logic [40:0]  w,
  output logic [68:0]  x
);

  // Specific opcodes recognised by the detectors and small lookup lists
  localparam logic [7:0] c_OP_NOP    = 8'h00;
  localparam logic [7:0] c_OP_STOP   = 8'h10;
  localparam logic [7:0] c_OP_HALT   = 8'h76;
  localparam logic [7:0] c_OP_PREFIX = 8'hCB;
  localparam logic [7:0] c_OP_DI     = 8'hF3;
  localparam logic [7:0] c_OP_EI     = 8'hFB;
  localparam logic [7:0] c_OP_JP_NN  = 8'hC3;
  localparam logic [7:0] c_OP_RET    = 8'hC9;
  localparam logic [7:0] c_OP_RETI   = 8'hD9;
  localparam logic [7:0] c_OP_CALL   = 8'hCD;

  // Opcode fields: X=IR[7:6], Y=IR[5:3], Z=IR[2:0], P=IR[5:4], Q=IR[3]
  logic [1:0] w_fx;
  logic [2:0] w_fy;
  logic [2:0] w_fz;
  logic [1:0] w_fp;
  logic       w_fq;
  logic       w_nc;

  assign w_fx = IR[7:6];
  assign w_fy = IR[5:3];
  assign w_fz = IR[2:0];
  assign w_fp = IR[5:4];
  assign w_fq = IR[3];
  assign w_nc = ~CB;

  logic [106:0] w_d;
  logic [40:0]  w_w;
  logic [68:0]  w_x;
  logic         w_inv_op;
  logic         w_ldh_op;
  logic         w_imm8_op;
  logic         w_imm16_op;

  logic [106:0] r_d;
  logic [40:0]  r_w;
  logic [68:0]  r_x;

  // Stage 1: one-hot field expansion plus specific-opcode detectors
  always_comb begin
    w_d          = '0;
    w_d[7:0]     = 8'd1 << w_fz;
    w_d[15:8]    = 8'd1 << w_fy;
    w_d[19:16]   = 4'd1 << w_fx;
    w_d[23:20]   = 4'd1 << w_fp;
    w_d[25:24]   = w_fq ? 2'b10 : 2'b01;
    w_d[26]      = CB;
    w_d[27]      = w_nc;
    // M-cycles 6 and 7 have no strobe; the group stays blank
    if (MCYC < 3'd6) begin
      w_d[33:28] = 6'd1 << MCYC;
    end
    w_d[97:34]   = 64'd1 << IR[7:2];
    w_d[98]      = w_nc & (IR == c_OP_NOP);
    w_d[99]      = w_nc & (IR == c_OP_HALT);
    w_d[100]     = w_nc & (IR == c_OP_STOP);
    w_d[101]     = w_nc & (IR == c_OP_PREFIX);
    w_d[102]     = w_nc & (IR == c_OP_DI);
    w_d[103]     = w_nc & (IR == c_OP_EI);
    w_d[104]     = w_nc & (IR == c_OP_JP_NN);
    w_d[105]     = w_nc & (IR == c_OP_RET);
    w_d[106]     = w_nc & (IR == c_OP_RETI);
  end

  // Opcode lists that do not follow the field structure
  always_comb begin
    w_inv_op   = 1'b0;
    w_ldh_op   = 1'b0;
    w_imm8_op  = 1'b0;
    w_imm16_op = 1'b0;
    case (IR)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: w_inv_op = 1'b1;
      default: w_inv_op = 1'b0;
    endcase
    case (IR)
      8'hE0, 8'hF0, 8'hE2, 8'hF2: w_ldh_op = 1'b1;
      default: w_ldh_op = 1'b0;
    endcase
    case (IR)
      8'hE0, 8'hF0, 8'hE8, 8'hF8: w_imm8_op = 1'b1;
      default: w_imm8_op = 1'b0;
    endcase
    case (IR)
      8'h08, 8'hEA, 8'hFA: w_imm16_op = 1'b1;
      default: w_imm16_op = 1'b0;
    endcase
  end

  // Stage 2: fold the stage-1 one-hots into instruction classes
  always_comb begin
    w_w     = '0;
    w_w[0]  = w_nc & w_d[17] & (IR != c_OP_HALT);
    w_w[1]  = w_nc & w_d[18];
    w_w[2]  = w_nc & w_d[19] & w_d[6];
    w_w[3]  = w_nc & w_d[16] & w_d[6];
    w_w[4]  = w_nc & w_d[16] & w_d[4];
    w_w[5]  = w_nc & w_d[16] & w_d[5];
    w_w[6]  = w_nc & w_d[16] & w_d[1] & w_d[24];
    w_w[7]  = w_nc & w_d[16] & w_d[1] & w_d[25];
    w_w[8]  = w_nc & w_d[16] & w_d[3] & w_d[24];
    w_w[9]  = w_nc & w_d[16] & w_d[3] & w_d[25];
    w_w[10] = w_nc & w_d[16] & w_d[0] & (w_fy >= 3'd3);
    w_w[11] = w_nc & w_d[16] & w_d[7];
    w_w[12] = w_nc & w_d[16] & w_d[2];
    w_w[13] = w_nc & w_d[19] & w_d[0] & (w_fy < 3'd4);
    w_w[14] = w_nc & w_d[19] & w_d[1] & w_d[24];
    w_w[15] = w_nc & w_d[19] & w_d[2] & (w_fy < 3'd4);
    w_w[16] = w_nc & w_d[19] & w_d[4] & (w_fy < 3'd4);
    w_w[17] = w_nc & w_d[19] & w_d[5] & w_d[24];
    w_w[18] = w_nc & w_d[19] & w_d[7];
    w_w[19] = w_nc & (IR == c_OP_CALL);
    w_w[20] = CB & w_d[16];
    w_w[21] = CB & w_d[17];
    w_w[22] = CB & w_d[18];
    w_w[23] = CB & w_d[19];
    w_w[24] = w_d[6];
    w_w[25] = w_d[14];
    w_w[26] = w_nc & w_inv_op;
    w_w[27] = w_nc & w_ldh_op;
  end

  // Stage 3: register selects, op selects and control strobes
  always_comb begin
    w_x        = '0;
    w_x[7:0]   = (w_w[0] | w_w[1] | w_w[20] | w_w[21] | w_w[22] | w_w[23]) ? w_d[7:0] : 8'd0;
    w_x[15:8]  = (w_w[0] | w_w[3] | w_w[4] | w_w[5]) ? w_d[15:8] : 8'd0;
    w_x[19:16] = (w_w[6] | w_w[7] | w_w[8] | w_w[9] | w_w[14] | w_w[17]) ? w_d[23:20] : 4'd0;
    w_x[27:20] = (w_w[1] | w_w[2]) ? w_d[15:8] : 8'd0;
    // JR cc only for Y>=4; plain JR (Y=3) carries no condition
    w_x[31:28] = (w_w[13] | w_w[15] | w_w[16] | (w_w[10] & (w_fy >= 3'd4)))
                 ? (4'd1 << IR[4:3]) : 4'd0;
    w_x[39:32] = w_w[18] ? w_d[15:8] : 8'd0;
    w_x[47:40] = (w_w[21] | w_w[22] | w_w[23]) ? w_d[15:8] : 8'd0;
    w_x[55:48] = w_w[20] ? w_d[15:8] : 8'd0;
    w_x[56]    = w_w[24] & (w_w[0] | w_w[1] | w_w[4] | w_w[5] |
                            w_w[20] | w_w[21] | w_w[22] | w_w[23]);
    w_x[57]    = (w_w[25] & (w_w[0] | w_w[3] | w_w[4] | w_w[5])) |
                 (w_w[24] & (w_w[20] | w_w[22] | w_w[23]));
    w_x[58]    = w_w[2] | w_w[3] | w_w[10] | (w_nc & w_imm8_op);
    w_x[59]    = w_w[6] | w_w[15] | w_w[16] | w_w[19] | w_d[104] | (w_nc & w_imm16_op);
    w_x[60]    = w_w[16] | w_w[17] | w_w[18] | w_w[19];
    w_x[61]    = w_w[13] | w_w[14] | w_d[105] | w_d[106];
    w_x[62]    = w_d[103] | w_d[106];
    w_x[63]    = w_d[102];
    w_x[64]    = w_d[99];
    w_x[65]    = w_d[100];
    w_x[66]    = w_d[101];
    w_x[67]    = w_w[26];
    w_x[68]    = ~w_w[26];
  end

  // Output registers: all three vectors captured together, cleared on reset
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_d <= '0;
      r_w <= '0;
      r_x <= '0;
    end else begin
      r_d <= w_d;
      r_w <= w_w;
      r_x <= w_x;
    end
  end

  assign d = r_d;
  assign w = r_w;
  assign x = r_x;

endmodule
`default_nettype wire

// File: tb/tb_sm83_decode_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sm83_decode_unit
//  Purpose  : Scoreboard bench for sm83_decode_unit against a loop-based
//             reference decoder, plus directed opcode and reset checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sm83_decode_unit;

  logic         CLK = 1'b0;
  logic         nRESET = 1'b1;
  logic [7:0]   IR = 8'h00;
  logic         CB = 1'b0;
  logic [2:0]   MCYC = 3'd0;
  logic [106:0] d;
  logic [40:0]  w;
  logic [68:0]  x;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [106:0] d;
    logic [40:0]  w;
    logic [68:0]  x;
  } snap_t;

  snap_t sb_q[$];

  always #5 CLK = ~CLK;

  sm83_decode_unit dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .IR     (IR),
    .CB     (CB),
    .MCYC   (MCYC),
    .d      (d),
    .w      (w),
    .x      (x)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] bv(input bit c, input int n);
    return c ? (128'd1 << n) : 128'd0;
  endfunction

  function automatic bit is_invalid(input logic [7:0] ir);
    logic [7:0] lst [11] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                             8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};
    for (int i = 0; i < 11; i++) if (lst[i] == ir) return 1'b1;
    return 1'b0;
  endfunction

  // Reference decoder written bit-by-bit from the opcode tables
  function automatic snap_t model(input logic [7:0] ir, input logic cb, input logic [2:0] mc);
    logic [127:0] ed, ew, ex;
    int X, Y, Z, P, Q;
    bit nc, en_a, en_b, en_c, en_d, en_e;
    snap_t s;
    X = int'(ir[7:6]); Y = int'(ir[5:3]); Z = int'(ir[2:0]);
    P = int'(ir[5:4]); Q = int'(ir[3]);
    nc = !cb;
    ed = '0; ew = '0; ex = '0;
    for (int i = 0; i < 8; i++) ed |= bv(Z == i, i) | bv(Y == i, 8 + i);
    for (int i = 0; i < 4; i++) ed |= bv(X == i, 16 + i) | bv(P == i, 20 + i);
    ed |= bv(Q == 0, 24) | bv(Q == 1, 25) | bv(cb, 26) | bv(nc, 27);
    for (int i = 0; i < 6; i++) ed |= bv(int'(mc) == i, 28 + i);
    for (int i = 0; i < 64; i++) ed |= bv(int'(ir[7:2]) == i, 34 + i);
    ed |= bv(nc && ir == 8'h00, 98)  | bv(nc && ir == 8'h76, 99)  | bv(nc && ir == 8'h10, 100)
        | bv(nc && ir == 8'hCB, 101) | bv(nc && ir == 8'hF3, 102) | bv(nc && ir == 8'hFB, 103)
        | bv(nc && ir == 8'hC3, 104) | bv(nc && ir == 8'hC9, 105) | bv(nc && ir == 8'hD9, 106);

    ew |= bv(nc && X == 1 && ir != 8'h76, 0) | bv(nc && X == 2, 1) | bv(nc && X == 3 && Z == 6, 2);
    ew |= bv(nc && X == 0 && Z == 6, 3) | bv(nc && X == 0 && Z == 4, 4) | bv(nc && X == 0 && Z == 5, 5);
    ew |= bv(nc && X == 0 && Z == 1 && Q == 0, 6) | bv(nc && X == 0 && Z == 1 && Q == 1, 7);
    ew |= bv(nc && X == 0 && Z == 3 && Q == 0, 8) | bv(nc && X == 0 && Z == 3 && Q == 1, 9);
    ew |= bv(nc && X == 0 && Z == 0 && Y >= 3, 10) | bv(nc && X == 0 && Z == 7, 11)
        | bv(nc && X == 0 && Z == 2, 12);
    ew |= bv(nc && X == 3 && Z == 0 && Y < 4, 13) | bv(nc && X == 3 && Z == 1 && Q == 0, 14)
        | bv(nc && X == 3 && Z == 2 && Y < 4, 15) | bv(nc && X == 3 && Z == 4 && Y < 4, 16)
        | bv(nc && X == 3 && Z == 5 && Q == 0, 17) | bv(nc && X == 3 && Z == 7, 18)
        | bv(nc && ir == 8'hCD, 19);
    for (int i = 0; i < 4; i++) ew |= bv(cb && X == i, 20 + i);
    ew |= bv(Z == 6, 24) | bv(Y == 6, 25) | bv(nc && is_invalid(ir), 26);
    ew |= bv(nc && (ir == 8'hE0 || ir == 8'hF0 || ir == 8'hE2 || ir == 8'hF2), 27);

    en_a = ew[0] | ew[1] | ew[20] | ew[21] | ew[22] | ew[23];
    en_b = ew[0] | ew[3] | ew[4] | ew[5];
    en_c = ew[6] | ew[7] | ew[8] | ew[9] | ew[14] | ew[17];
    en_d = ew[1] | ew[2];
    en_e = ew[13] | ew[15] | ew[16] | (ew[10] && Y >= 4);
    for (int i = 0; i < 8; i++) begin
      ex |= bv(en_a && Z == i, i) | bv(en_b && Y == i, 8 + i) | bv(en_d && Y == i, 20 + i);
      ex |= bv(ew[18] && Y == i, 32 + i) | bv((ew[21] | ew[22] | ew[23]) && Y == i, 40 + i);
      ex |= bv(ew[20] && Y == i, 48 + i);
    end
    for (int i = 0; i < 4; i++)
      ex |= bv(en_c && P == i, 16 + i) | bv(en_e && int'(ir[4:3]) == i, 28 + i);
    ex |= bv(ew[24] && (ew[0] | ew[1] | ew[4] | ew[5] | ew[20] | ew[21] | ew[22] | ew[23]), 56);
    ex |= bv((ew[25] && (ew[0] | ew[3] | ew[4] | ew[5])) || (ew[24] && (ew[20] | ew[22] | ew[23])), 57);
    ex |= bv(ew[2] | ew[3] | ew[10] | (nc && (ir == 8'hE0 || ir == 8'hF0 || ir == 8'hE8 || ir == 8'hF8)), 58);
    ex |= bv(ew[6] | ew[15] | ew[16] | ew[19] | (nc && (ir == 8'hC3 || ir == 8'h08 || ir == 8'hEA || ir == 8'hFA)), 59);
    ex |= bv(ew[16] | ew[17] | ew[18] | ew[19], 60);
    ex |= bv(ew[13] | ew[14] | (nc && (ir == 8'hC9 || ir == 8'hD9)), 61);
    ex |= bv(nc && (ir == 8'hFB || ir == 8'hD9), 62) | bv(nc && ir == 8'hF3, 63);
    ex |= bv(nc && ir == 8'h76, 64) | bv(nc && ir == 8'h10, 65) | bv(nc && ir == 8'hCB, 66);
    ex |= bv(ew[26], 67) | bv(!ew[26], 68);
    s.d = ed[106:0];
    s.w = ew[40:0];
    s.x = ex[68:0];
    return s;
  endfunction

  // Drive one opcode, queue its expected snapshot, compare after the edge
  task automatic step(input logic [7:0] ir, input logic cb, input logic [2:0] mc);
    snap_t e;
    @(negedge CLK);
    IR = ir; CB = cb; MCYC = mc;
    sb_q.push_back(model(ir, cb, mc));
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 128'd1, 128'd0);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("d ir=%h cb=%0d mc=%0d", ir, cb, mc), 128'(d), 128'(e.d));
      check($sformatf("w ir=%h cb=%0d", ir, cb), 128'(w), 128'(e.w));
      check($sformatf("x ir=%h cb=%0d", ir, cb), 128'(x), 128'(e.x));
    end
  endtask

  initial begin
    // Power-on reset, asserted between edges
    #2 nRESET = 1'b0;
    #1;
    check("rst_d", 128'(d), 128'd0);
    check("rst_w", 128'(w), 128'd0);
    check("rst_x", 128'(x), 128'd0);
    @(negedge CLK);
    nRESET = 1'b1;

    // LD B,C
    step(8'h41, 1'b0, 3'd0);
    check("41_d1",  128'(d[1]),  128'd1);
    check("41_d8",  128'(d[8]),  128'd1);
    check("41_d17", 128'(d[17]), 128'd1);
    check("41_d28", 128'(d[28]), 128'd1);
    check("41_d50", 128'(d[50]), 128'd1);
    check("41_w0",  128'(w[0]),  128'd1);
    check("41_x1",  128'(x[1]),  128'd1);
    check("41_x8",  128'(x[8]),  128'd1);
    check("41_x68", 128'(x[68]), 128'd1);
    check("41_x56_57", 128'(x[57:56]), 128'd0);

    // HALT
    step(8'h76, 1'b0, 3'd0);
    check("76_d99", 128'(d[99]), 128'd1);
    check("76_w24_25", 128'(w[25:24]), 128'd3);
    check("76_x64", 128'(x[64]), 128'd1);
    check("76_w0",  128'(w[0]),  128'd0);
    check("76_x57", 128'(x[57]), 128'd0);

    // BIT 7,(HL)
    step(8'h7E, 1'b1, 3'd1);
    check("cb7e_w21", 128'(w[21]), 128'd1);
    check("cb7e_w24", 128'(w[24]), 128'd1);
    check("cb7e_x6",  128'(x[6]),  128'd1);
    check("cb7e_x47", 128'(x[47]), 128'd1);
    check("cb7e_x56", 128'(x[56]), 128'd1);
    check("cb7e_x68", 128'(x[68]), 128'd1);
    check("cb7e_d99", 128'(d[99]), 128'd0);

    // Invalid opcode, then CALL nn
    step(8'hD3, 1'b0, 3'd0);
    check("d3_w26", 128'(w[26]), 128'd1);
    check("d3_x67", 128'(x[67]), 128'd1);
    check("d3_x68", 128'(x[68]), 128'd0);
    step(8'hCD, 1'b0, 3'd0);
    check("cd_w19", 128'(w[19]), 128'd1);
    check("cd_x59", 128'(x[59]), 128'd1);
    check("cd_x60", 128'(x[60]), 128'd1);

    // MCYC boundary: 5 is the last strobed cycle, 6 and 7 blank the group
    step(8'h00, 1'b0, 3'd5);
    check("mc5", 128'(d[33:28]), 128'h20);
    step(8'h00, 1'b0, 3'd6);
    check("mc6", 128'(d[33:28]), 128'd0);
    step(8'h00, 1'b0, 3'd7);
    check("mc7", 128'(d[33:28]), 128'd0);

    // Asynchronous reset mid-run: clears without an edge and holds
    step(8'hC9, 1'b0, 3'd2);
    #2 nRESET = 1'b0;
    #1;
    check("arst_d", 128'(d), 128'd0);
    check("arst_w", 128'(w), 128'd0);
    check("arst_x", 128'(x), 128'd0);
    @(posedge CLK);
    #1;
    check("arst_hold_x", 128'(x), 128'd0);
    @(negedge CLK);
    nRESET = 1'b1;
    step(8'hFB, 1'b0, 3'd0);
    check("post_rst_x62", 128'(x[62]), 128'd1);

    // Full opcode sweep, both tables, MCYC cycling through all values
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] op;
        logic [2:0] mc;
        bit grp_ok;
        op = 8'(i);
        mc = 3'(i);
        step(op, c[0], mc);
        grp_ok = ($countones(d[7:0]) == 1) && ($countones(d[15:8]) == 1) &&
                 ($countones(d[19:16]) == 1) && ($countones(d[23:20]) == 1) &&
                 ($countones(d[25:24]) == 1) && ($countones(d[97:34]) == 1) &&
                 ($countones(d[33:28]) == ((mc < 3'd6) ? 1 : 0)) &&
                 ($countones(x[7:0]) <= 1) && ($countones(x[15:8]) <= 1) &&
                 ($countones(x[19:16]) <= 1) && ($countones(x[27:20]) <= 1) &&
                 ($countones(x[31:28]) <= 1) && ($countones(x[39:32]) <= 1) &&
                 ($countones(x[47:40]) <= 1) && ($countones(x[55:48]) <= 1);
        check($sformatf("onehot ir=%h cb=%0d", op, c), 128'(grp_ok), 128'd1);
        check($sformatf("x67 ir=%h cb=%0d", op, c), 128'(x[67]),
              128'((c == 0) && is_invalid(op)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
